// File: rtl/ps2kb_decoder_if.sv
// Byte-stream input and key-event output bundle for ps2kb_decoder.
interface ps2kb_decoder_if;
  logic       rx_done_tick;
  logic [7:0] din;
  logic       ev_rd;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_break;
  logic       ev_ext;
  logic [7:0] ev_ascii;
  logic       shift;
  logic       ctrl;
  logic       alt;
  logic       overflow;

  modport master (
    output rx_done_tick, din, ev_rd,
    input  ev_valid, ev_code, ev_break, ev_ext, ev_ascii, shift, ctrl, alt, overflow
  );

  modport slave (
    input  rx_done_tick, din, ev_rd,
    output ev_valid, ev_code, ev_break, ev_ext, ev_ascii, shift, ctrl, alt, overflow
  );
endinterface

// File: rtl/ps2kb_decoder.sv
// PS/2 Set-2 scan-code decoder: prefix FSM, modifier tracking, FWFT event FIFO.
// Define PS2KB_ASCII_EN to build the ASCII translation and widen FIFO entries to 18 bits.
module ps2kb_decoder #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input logic            clk,
  input logic            rst,
  ps2kb_decoder_if.slave kb
);

`ifdef PS2KB_ASCII_EN
  localparam int unsigned W = 18;
`else
  localparam int unsigned W = 10;
`endif
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

  state_t       state_q, state_d;
  logic [2:0]   skip_q, skip_d;
  logic         emit;
  logic [7:0]   e_code;
  logic         e_brk, e_ext;
  logic [W-1:0] e_entry;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    emit    = 1'b0;
    e_code  = kb.din;
    e_brk   = 1'b0;
    e_ext   = 1'b0;
    if (kb.rx_done_tick) begin
      if (state_q == PAUSE) begin
        // pause payload is skipped blindly; the last byte emits a synthetic E1 event
        skip_d = skip_q - 3'd1;
        if (skip_q == 3'd1) begin
          emit    = 1'b1;
          e_code  = 8'hE1;
          state_d = IDLE;
        end
      end else begin
        case (kb.din)
          8'hE0: state_d = (state_q == BRK || state_q == EXT_BRK) ? EXT_BRK : EXT;
          8'hF0: state_d = (state_q == EXT || state_q == EXT_BRK) ? EXT_BRK : BRK;
          8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: state_d = IDLE;
          default: begin
            if (kb.din == 8'hE1 && state_q == IDLE) begin
              state_d = PAUSE;
              skip_d  = 3'd7;
            end else begin
              emit    = 1'b1;
              e_brk   = (state_q == BRK || state_q == EXT_BRK);
              e_ext   = (state_q == EXT || state_q == EXT_BRK);
              state_d = IDLE;
            end
          end
        endcase
      end
    end
  end

  logic lshift_q, rshift_q, lctrl_q, rctrl_q, lalt_q, ralt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      lctrl_q  <= 1'b0;
      rctrl_q  <= 1'b0;
      lalt_q   <= 1'b0;
      ralt_q   <= 1'b0;
    end else if (emit) begin
      if (e_code == 8'h12 && !e_ext) lshift_q <= !e_brk;
      if (e_code == 8'h59 && !e_ext) rshift_q <= !e_brk;
      if (e_code == 8'h14) begin
        if (e_ext) rctrl_q <= !e_brk;
        else       lctrl_q <= !e_brk;
      end
      if (e_code == 8'h11) begin
        if (e_ext) ralt_q <= !e_brk;
        else       lalt_q <= !e_brk;
      end
    end
  end

  assign kb.shift = lshift_q | rshift_q;
  assign kb.ctrl  = lctrl_q | rctrl_q;
  assign kb.alt   = lalt_q | ralt_q;

  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          ovf_q;
  logic          full, empty, push, pop, drop;
  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  head;

`ifdef PS2KB_ASCII_EN
  function automatic logic [7:0] to_ascii(input logic [7:0] code, input logic sh);
    logic [7:0] a;
    a = 8'h00;
    case (code)
      8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
      8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
      8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
      8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
      8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
      8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
      8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
      8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
      8'h3E: a = 8'h38; 8'h46: a = 8'h39;
      8'h29: a = 8'h20; 8'h5A: a = 8'h0D; 8'h66: a = 8'h08;
      default: a = 8'h00;
    endcase
    if (sh && a >= 8'h61 && a <= 8'h7A) a = a - 8'h20;
    return a;
  endfunction

  // uses the registered shift, i.e. the state before this event's own update
  assign e_entry     = {(!e_brk && !e_ext) ? to_ascii(e_code, kb.shift) : 8'h00, e_ext, e_brk, e_code};
  assign kb.ev_ascii = head[17:10];
`else
  assign e_entry     = {e_ext, e_brk, e_code};
  assign kb.ev_ascii = '0;
`endif

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign pop   = kb.ev_rd && !empty;
  assign push  = emit && (!full || pop);
  assign drop  = emit && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= e_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign head        = mem[rptr_q];
  assign kb.ev_valid = !empty;
  assign kb.ev_code  = head[7:0];
  assign kb.ev_break = head[8];
  assign kb.ev_ext   = head[9];
  assign kb.overflow = ovf_q;

endmodule
